// File: rtl/io_pkg.sv
// Shared definitions for the board-input front end: bit ranges of the
// button/switch groups, default timing parameters and a counter-width helper.
package io_pkg;

  // Bit ranges of the raw input vector
  localparam int BTN_LO = 0;
  localparam int BTN_HI = 3;
  localparam int SW_LO  = 4;
  localparam int SW_HI  = 11;

  // Defaults: 1 kHz sample tick at 50 MHz, 8 agreeing ticks to flip
  localparam int N_IN_DEF   = 12;
  localparam int PRESC_DEF  = 50000;
  localparam int STABLE_DEF = 8;

  // Width of a counter that must hold values 0..max_val
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_in_if.sv
// Bus between the input front end and its consumer (the computer's input
// ports). The falling-event vector exists only when DEBOUNCE_FALL_EVT_EN
// is defined.
interface debounce_in_if #(
  parameter int N_IN = 12
);

  logic [N_IN-1:0] raw;
  logic [N_IN-1:0] state;
  logic [N_IN-1:0] evt;
  logic            clr_we;
  logic [N_IN-1:0] clr_mask;
  logic [N_IN-1:0] irq_mask;
  logic            irq;
  logic            tick;
`ifdef DEBOUNCE_FALL_EVT_EN
  logic [N_IN-1:0] fevt;

  modport master (
    output raw, clr_we, clr_mask, irq_mask,
    input  state, evt, fevt, irq, tick
  );

  modport slave (
    input  raw, clr_we, clr_mask, irq_mask,
    output state, evt, fevt, irq, tick
  );
`else
  modport master (
    output raw, clr_we, clr_mask, irq_mask,
    input  state, evt, irq, tick
  );

  modport slave (
    input  raw, clr_we, clr_mask, irq_mask,
    output state, evt, irq, tick
  );
`endif

endinterface

// File: rtl/deb_cell.sv
// One debounced input line: 2-FF synchronizer, stable counter and the
// debounced level flop. The counter only advances on sample ticks, and any
// agreeing sample restarts it, so short glitches never reach the output.
module deb_cell
  import io_pkg::*;
#(
  parameter int STABLE = STABLE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic state
);

  localparam int CW = cnt_width(STABLE);

  logic [1:0]    sync;
  logic          raw_s;
  logic [CW-1:0] count;

  assign raw_s = sync[1];

  // Two-flop synchronizer for the asynchronous board input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], raw};
    end
  end

  // Count consecutive disagreeing ticks; flip the level after STABLE of them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      state <= 1'b0;
    end else if (tick) begin
      if (raw_s == state) begin
        count <= '0;
      end else if (count == CW'(STABLE - 1)) begin
        state <= raw_s;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/debounce_in.sv
// Board-input front end: sample-tick prescaler, one debounce cell per input,
// rising-edge event latches with write-1-to-clear and a registered interrupt.
// Optional feature macro: DEBOUNCE_FALL_EVT_EN adds falling-edge events
// (fevt) that share the clear path and also feed the interrupt.
module debounce_in
  import io_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int PRESC  = PRESC_DEF,
  parameter int STABLE = STABLE_DEF
) (
  input logic          clk,
  input logic          reset,
  debounce_in_if.slave bus
);

  localparam int PW = cnt_width(PRESC);

  logic [PW-1:0]   presc_cnt;
  logic [PW-1:0]   presc_next;
  logic            tick;
  logic [N_IN-1:0] state;
  logic [N_IN-1:0] state_d;
  logic [N_IN-1:0] clr_bits;
  logic [N_IN-1:0] evt;
  logic [N_IN-1:0] irq_src;
  logic            irq;
`ifdef DEBOUNCE_FALL_EVT_EN
  logic [N_IN-1:0] fevt;
`endif

  // Prescaler next value: count 0..PRESC-1 and wrap
  always_comb begin
    presc_next = presc_cnt + 1'b1;
    if (presc_cnt == PW'(PRESC - 1)) begin
      presc_next = '0;
    end
  end

  // Prescaler and registered tick; tick tracks counter==PRESC-1 (constant 1
  // once out of reset when PRESC is 1)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_cnt <= '0;
      tick      <= 1'b0;
    end else begin
      presc_cnt <= presc_next;
      tick      <= (presc_next == PW'(PRESC - 1));
    end
  end

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_cell
    deb_cell #(
      .STABLE (STABLE)
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.raw[gi]),
      .tick  (tick),
      .state (state[gi])
    );
  end

  assign clr_bits = bus.clr_we ? bus.clr_mask : '0;

  // Previous-cycle debounced levels for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_d <= '0;
    end else begin
      state_d <= state;
    end
  end

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_evt
    logic rise_bit;
    logic evt_bit;

    assign rise_bit = state[gi] & ~state_d[gi];

    // Sticky rising-edge latch; a new edge beats a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        evt_bit <= 1'b0;
      end else if (rise_bit) begin
        evt_bit <= 1'b1;
      end else if (clr_bits[gi]) begin
        evt_bit <= 1'b0;
      end
    end

    assign evt[gi] = evt_bit;

`ifdef DEBOUNCE_FALL_EVT_EN
    logic fall_bit;
    logic fevt_bit;

    assign fall_bit = ~state[gi] & state_d[gi];

    // Sticky falling-edge latch with the same clear and set-wins behaviour
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        fevt_bit <= 1'b0;
      end else if (fall_bit) begin
        fevt_bit <= 1'b1;
      end else if (clr_bits[gi]) begin
        fevt_bit <= 1'b0;
      end
    end

    assign fevt[gi] = fevt_bit;
`endif
  end

`ifdef DEBOUNCE_FALL_EVT_EN
  assign irq_src = evt | fevt;
  assign bus.fevt = fevt;
`else
  assign irq_src = evt;
`endif

  // Interrupt is the registered OR of enabled sticky events
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(irq_src & bus.irq_mask);
    end
  end

  assign bus.state = state;
  assign bus.evt   = evt;
  assign bus.irq   = irq;
  assign bus.tick  = tick;

endmodule
